// File: rtl/clock_pkg.sv
// Shared constants for the chess-clock time chain: digit widths, digit
// limits and the default prescaler divide ratio.
package clock_pkg;

    // Width of one BCD digit
    localparam int BCD_W = 4;

    // Largest legal value of each seconds digit; the minute stage reuses these
    localparam logic [BCD_W-1:0] SEC_UNITS_MAX = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX  = 4'd5;

    // System clock cycles per one-second tick
    localparam int TICK_DIV_DEFAULT = 50_000_000;

    // Limit a preset digit to its maximum so that out-of-range BCD states
    // can never be entered
    function automatic logic [BCD_W-1:0] clamp_digit(
        input logic [BCD_W-1:0] value,
        input logic [BCD_W-1:0] max_value
    );
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that produces one raw tick per TICK_DIV enabled
// cycles. The count holds while CE is low, so a paused player resumes the
// partial second instead of starting over.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLK,
    input  logic CLR,
    input  logic CE,
    input  logic SYNC_CLR,
    output logic TICK_RAW
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_term;

    assign at_term  = (cnt_q == TERM);
    // Raw tick is combinational so the digit logic can act on the same edge
    assign TICK_RAW = at_term & CE;

    // Next-count computation: clear, hold on pause, or advance with wrap
    always_comb begin
        cnt_d = cnt_q;
        if (SYNC_CLR) begin
            cnt_d = '0;
        end else if (CE) begin
            if (at_term) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Prescaler register with synchronous clear
    always_ff @(posedge CLK) begin
        if (CLR) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/second_stage.sv
// Seconds stage of the chess-clock time chain: BCD seconds 00-59 advanced
// by the prescaler tick, with registered TICK and MIN_IMPULSE pulses that
// line up with the new digit values.
module second_stage
    import clock_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CE,
    input  logic             LOAD,
    input  logic [BCD_W-1:0] LOAD_TENS,
    input  logic [BCD_W-1:0] LOAD_UNITS,
    output logic [BCD_W-1:0] TENS,
    output logic [BCD_W-1:0] UNITS,
    output logic             TICK,
    output logic             MIN_IMPULSE
);

    logic             tick_raw;
    logic             sec_event;
    logic             units_at_max;
    logic             tens_at_max;

    logic [BCD_W-1:0] tens_q,  tens_d;
    logic [BCD_W-1:0] units_q, units_d;
    logic             tick_q,  tick_d;
    logic             min_q,   min_d;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLK      (CLK),
        .CLR      (CLR),
        .CE       (CE),
        .SYNC_CLR (LOAD),
        .TICK_RAW (tick_raw)
    );

    // A load on the terminal-count cycle swallows the second event; a
    // coincident CLR is handled by the register reset below
    assign sec_event    = tick_raw & ~LOAD;
    assign units_at_max = (units_q == SEC_UNITS_MAX);
    assign tens_at_max  = (tens_q  == SEC_TENS_MAX);

    // Digit advance, preset clamping and pulse generation
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        tick_d  = 1'b0;
        min_d   = 1'b0;
        if (LOAD) begin
            tens_d  = clamp_digit(LOAD_TENS,  SEC_TENS_MAX);
            units_d = clamp_digit(LOAD_UNITS, SEC_UNITS_MAX);
        end else if (sec_event) begin
            tick_d = 1'b1;
            if (!units_at_max) begin
                units_d = units_q + 1'b1;
            end else if (!tens_at_max) begin
                units_d = '0;
                tens_d  = tens_q + 1'b1;
            end else begin
                units_d = '0;
                tens_d  = '0;
                min_d   = 1'b1;
            end
        end
    end

    // State and output registers with synchronous clear
    always_ff @(posedge CLK) begin
        if (CLR) begin
            tens_q  <= '0;
            units_q <= '0;
            tick_q  <= 1'b0;
            min_q   <= 1'b0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
            tick_q  <= tick_d;
            min_q   <= min_d;
        end
    end

    assign TENS        = tens_q;
    assign UNITS       = units_q;
    assign TICK        = tick_q;
    assign MIN_IMPULSE = min_q;

endmodule

// File: tb/tb_second_stage.sv
// Testbench for second_stage with TICK_DIV = 4. A reference model tracks
// elapsed seconds as an integer and the prescaler phase as a cycle count;
// every applied cycle is compared against it, plus directed checks.
module tb_second_stage;

    localparam int DIV = 4;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       CE = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] LOAD_TENS = 4'd0;
    logic [3:0] LOAD_UNITS = 4'd0;
    logic [3:0] TENS;
    logic [3:0] UNITS;
    logic       TICK;
    logic       MIN_IMPULSE;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int ph = 0;
    int secs = 0;
    bit exp_tick = 1'b0;
    bit exp_min = 1'b0;

    // observed pulse bookkeeping
    int tick_seen = 0;
    int min_seen = 0;

    second_stage #(.TICK_DIV(DIV)) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .CE          (CE),
        .LOAD        (LOAD),
        .LOAD_TENS   (LOAD_TENS),
        .LOAD_UNITS  (LOAD_UNITS),
        .TENS        (TENS),
        .UNITS       (UNITS),
        .TICK        (TICK),
        .MIN_IMPULSE (MIN_IMPULSE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge
    task automatic step(input bit clr, input bit load, input int lt, input int lu, input bit ce);
        CLR = clr; LOAD = load; LOAD_TENS = 4'(lt); LOAD_UNITS = 4'(lu); CE = ce;
        @(posedge CLK);
        exp_tick = 1'b0;
        exp_min  = 1'b0;
        if (clr) begin
            ph = 0; secs = 0;
        end else if (load) begin
            ph = 0;
            secs = ((lt > 5) ? 5 : lt) * 10 + ((lu > 9) ? 9 : lu);
        end else if (ce) begin
            if (ph == DIV - 1) begin
                ph = 0;
                secs = (secs + 1) % 60;
                exp_tick = 1'b1;
                exp_min = (secs == 0);
            end else begin
                ph = ph + 1;
            end
        end
        #1;
        if (TICK === 1'b1) tick_seen++;
        if (MIN_IMPULSE === 1'b1) min_seen++;
        chk("tens",  int'(TENS),  secs / 10);
        chk("units", int'(UNITS), secs % 10);
        chk("tick",  int'(TICK),  int'(exp_tick));
        chk("min",   int'(MIN_IMPULSE), int'(exp_min));
    endtask

    task automatic run(input int n, input bit ce);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, ce);
    endtask

    initial begin
        int t0;
        // 1: reset and first tick
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        chk("rst_units", int'(UNITS), 0);
        chk("rst_tick", int'(TICK), 0);
        run(3, 1'b1);
        chk("pre_tick", int'(TICK), 0);
        run(1, 1'b1);
        chk("first_tick", int'(TICK), 1);
        chk("first_units", int'(UNITS), 1);
        t0 = tick_seen;
        run(3 * DIV, 1'b1);
        chk("period_ticks", tick_seen - t0, 3);

        // 2: wrap from 58
        step(1'b0, 1'b1, 5, 8, 1'b0);
        min_seen = 0;
        run(DIV, 1'b1);
        chk("no_min_58_59", min_seen, 0);
        chk("at59_units", int'(UNITS), 9);
        run(DIV, 1'b1);
        chk("wrap_min", int'(MIN_IMPULSE), 1);
        chk("wrap_tick", int'(TICK), 1);
        run(1, 1'b1);
        chk("wrap_min_width", int'(MIN_IMPULSE), 0);

        // 3: pause
        step(1'b0, 1'b1, 0, 0, 1'b0);
        run(2, 1'b1);
        t0 = tick_seen;
        run(10, 1'b0);
        chk("pause_no_tick", tick_seen - t0, 0);
        run(1, 1'b1);
        chk("resume_no_tick", int'(TICK), 0);
        run(1, 1'b1);
        chk("resume_tick", int'(TICK), 1);

        // 3b: CE drops on the terminal-count cycle, event waits for resume
        step(1'b0, 1'b1, 0, 0, 1'b0);
        run(3, 1'b1);
        run(3, 1'b0);
        chk("held_no_tick", int'(TICK), 0);
        run(1, 1'b1);
        chk("held_resume_tick", int'(TICK), 1);
        run(1, 1'b0);
        chk("pulse_one_cycle", int'(TICK), 0);

        // 4: load clamp
        step(1'b0, 1'b1, 9, 15, 1'b1);
        chk("clamp_tens", int'(TENS), 5);
        chk("clamp_units", int'(UNITS), 9);
        run(DIV, 1'b1);
        chk("clamp_wrap_min", int'(MIN_IMPULSE), 1);

        // 5: collisions at 59 on the terminal-count cycle
        step(1'b0, 1'b1, 5, 9, 1'b0);
        run(DIV - 1, 1'b1);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        chk("clr_coll_tick", int'(TICK), 0);
        chk("clr_coll_units", int'(UNITS), 0);
        step(1'b0, 1'b1, 5, 9, 1'b0);
        run(DIV - 1, 1'b1);
        step(1'b0, 1'b1, 3, 0, 1'b1);
        chk("load_coll_tens", int'(TENS), 3);
        chk("load_coll_tick", int'(TICK), 0);

        // 6: chain check, 120 seconds from 00
        step(1'b0, 1'b1, 0, 0, 1'b0);
        min_seen = 0;
        run(120 * DIV, 1'b1);
        chk("chain_min_pulses", min_seen, 2);
        chk("chain_minute_units", min_seen % 10, 2);

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step(r < 2, (r >= 2 && r < 6), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/second_stage.md
# second_stage

Seconds stage of the chess-clock time chain. Divides the system clock into a one-second tick and counts seconds 00–59 in BCD. Emits a one-cycle minute impulse on every 59→00 wrap. Sits directly upstream of the minute counter and drives its impulse input; its own CE is the per-player run enable.

## Interface

Parameters:
- TICK_DIV, 50_000_000 — CLK cycles per second tick; must be ≥ 2.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- CLR  input  1  synchronous, active-high reset.
- CE  input  1  run enable; low freezes the prescaler and seconds count.
- LOAD  input  1  synchronous preset strobe.
- LOAD_TENS  input  4  preset value for the tens digit.
- LOAD_UNITS  input  4  preset value for the units digit.
- TENS  output  4  seconds tens digit, BCD 0–5.
- UNITS  output  4  seconds units digit, BCD 0–9.
- TICK  output  1  one-cycle pulse per elapsed second.
- MIN_IMPULSE  output  1  one-cycle pulse on the 59→00 wrap; connects to the minute counter's IMPULSE.

## Operation

- **Priority:** CLR > LOAD > CE counting.
- **CLR:** prescaler = 0, TENS = 0, UNITS = 0, TICK = 0, MIN_IMPULSE = 0. All outputs reset to 0.
- **LOAD (CLR low):**
  - TENS ← min(LOAD_TENS, 5); UNITS ← min(LOAD_UNITS, 9).
  - Prescaler ← 0. TICK and MIN_IMPULSE ← 0.
  - A load never generates an impulse, even when loading 00.
- **Prescaler:** counts 0..TICK_DIV−1 while CE = 1. Holds its value while CE = 0; it is not cleared on pause, so resume continues the partial second. Width is clog2(TICK_DIV).
- **Second event:** prescaler = TICK_DIV−1 with CE = 1. Prescaler wraps to 0 and the digits advance:
  - UNITS < 9 → UNITS + 1.
  - UNITS = 9, TENS < 5 → UNITS = 0, TENS + 1.
  - UNITS = 9, TENS = 5 → 00 and wrap flagged.
- Digits hold under any other condition.
- **Arithmetic:** 4-bit BCD per digit. Out-of-range states are unreachable because loads clamp.

## Timing

- **TICK and MIN_IMPULSE are registered.**
  - Both are high exactly during the cycle after the edge on which the digits advanced, i.e. concurrent with the new digit values.
  - MIN_IMPULSE is high only together with TICK, and only when TENS:UNITS = 00 was reached by wrapping.
- **Pause:**
  - CE falling in the same cycle the prescaler sits at TICK_DIV−1: no event; the prescaler holds at TICK_DIV−1.
  - The event fires on the first edge after CE returns high.
- **Pulse width:** each event produces exactly one TICK cycle, even if CE drops the following cycle. Pulses are cleared on the next edge regardless of CE.
- **Latency and period:**
  - From CLR release with CE held high, the first TICK is high TICK_DIV cycles after the release edge.
  - Thereafter TICK has a period of exactly TICK_DIV cycles.
- **Simultaneous events:**
  - CLR or LOAD in the same cycle as a second event suppresses the event; no pulse is produced.
  - A reset mid-second discards the partial prescaler count.

## Structure

- **Shared package** clock_pkg holds:
  - SEC_UNITS_MAX = 9 and SEC_TENS_MAX = 5 (reused by the minute stage's MAX values).
  - The BCD digit width constant, 4.
  - The default TICK_DIV.
- **Sub-module tick_prescaler:** parameter TICK_DIV; ports CLK, CLR, CE, SYNC_CLR (driven by LOAD), TICK_RAW (combinational terminal-count AND CE).
- **second_stage** contains the BCD digit logic and the registered TICK/MIN_IMPULSE outputs.

## Test plan

All scenarios use TICK_DIV = 4.

1. **Reset and first tick:** CLR for 2 cycles, then CE = 1.
   - Outputs read 0 during reset.
   - TICK is high for 1 cycle, 4 cycles after release; UNITS = 1 in that same cycle.
   - Continuous run → TICK period of 4 cycles.
2. **Wrap:** LOAD 5,8 then CE = 1.
   - After 2 ticks, TENS:UNITS = 00.
   - MIN_IMPULSE is high for exactly that one cycle, coincident with TICK.
   - There is no MIN_IMPULSE on the 58→59 tick.
3. **Pause:** CE = 1 for 2 cycles, CE = 0 for 10 cycles, then CE = 1.
   - No TICK while paused; the digits hold.
   - TICK arrives after 2 further running cycles, for 4 running cycles total.
4. **Load clamp:** LOAD with LOAD_TENS = 9, LOAD_UNITS = 15.
   - TENS = 5, UNITS = 9 on the next cycle; no TICK or MIN_IMPULSE.
   - The next tick wraps to 00 with MIN_IMPULSE = 1.
5. **Collision:** CLR asserted in the terminal-count cycle at 59.
   - Outputs go to 00 with no TICK and no MIN_IMPULSE.
   - Repeat with LOAD 3,0 instead of CLR → reads 30, no pulses.
6. **Chain check:** connect to the minute counter and run 120 seconds from 00.
   - Minute UNITS = 2; exactly 2 MIN_IMPULSE pulses are counted.
